cpu_sequencer: RTL

//  Multi-cycle fetch/execute sequencer for the A/B-register CPU. Owns the PC, instruction

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/seq_pc_reg.sv | 26 ++
 rtl/cpu_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the A/B-register CPU sequencer.
//  - FSM state encodings (2-bit)
//  - HALT opcode and the jump-class opcodes that leave the status register untouched
//  - status flag bit positions {Z,N,C,V}
package cpu_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [6:0] OP_HALT = 7'h7F;

  // Jump-class opcodes: conditional branches (two 5-bit prefixes) and JMP.
  localparam logic [4:0] JPFX_A = 5'b10101;
  localparam logic [4:0] JPFX_B = 5'b10110;
  localparam logic [6:0] OP_JMP = 7'b1010011;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // True for opcodes whose commit must not overwrite the status register.
  function automatic logic keeps_status(input logic [6:0] op);
    return (op[6:2] == JPFX_A) || (op[6:2] == JPFX_B) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/seq_pc_reg.sv
// Program counter register.
//  clk, rst_n : clock, asynchronous active-low reset (PC -> 0)
//  en         : update PC this cycle (asserted in the commit cycle)
//  load       : 1 = take load_val, 0 = increment (wraps 2^PC_W-1 -> 0)
//  load_val   : jump target
//  pc         : current PC
module seq_pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (en) begin
      pc <= load ? load_val : pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns PC, IR and the {Z,N,C,V} status register.
//  clk, rst_n  : clock, asynchronous active-low reset
//  run         : level, free-run when 1
//  step        : one-cycle pulse, executes one instruction (only seen in IDLE with run=0)
//  rom_data    : instruction word {opcode[6:0], lit}
//  rom_addr    : ROM address (= PC)
//  opcode, lit : IR fields to control unit / datapath
//  lpc         : load PC with lit in the commit cycle
//  alu_flags   : {Z,N,C,V} from the ALU
//  status      : registered {Z,N,C,V}
//  exec_en     : one-cycle commit window (EXEC state)
//  halted      : high in HALT
//  state_dbg   : current FSM state
// Handshake: there is no back-pressure; exec_en is a single-cycle strobe and the
// datapath commits exactly when exec_en=1 at a rising edge.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter int         LIT_W   = 8,
  parameter logic [6:0] OP_HALT = cpu_pkg::OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic [LIT_W+6:0]   rom_data,
  output logic [PC_W-1:0]    rom_addr,
  output logic [6:0]         opcode,
  output logic [LIT_W-1:0]   lit,
  input  logic               lpc,
  input  logic [3:0]         alu_flags,
  output logic [3:0]         status,
  output logic               exec_en,
  output logic               halted,
  output logic [1:0]         state_dbg
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LIT_W+6:0] ir;
  logic             step_latch;
  logic [PC_W-1:0]  pc;
  logic [3:0]       flags_in;

  assign opcode    = ir[LIT_W+6:LIT_W];
  assign lit       = ir[LIT_W-1:0];
  assign rom_addr  = pc;
  // Decoded from the state register so a reset in EXEC drops it immediately.
  assign exec_en   = (state == S_EXEC);
  assign halted    = (state == S_HALT);
  assign state_dbg = state;
  assign flags_in  = {alu_flags[FLAG_Z], alu_flags[FLAG_N],
                      alu_flags[FLAG_C], alu_flags[FLAG_V]};

  seq_pc_reg #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (exec_en),
    .load     (lpc),
    .load_val (lit[PC_W-1:0]),
    .pc       (pc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run || step) state_nxt = S_FETCH;
      S_FETCH: state_nxt = (rom_data[LIT_W+6:LIT_W] == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:  state_nxt = (run && !step_latch) ? S_FETCH : S_IDLE;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ir         <= '0;
      status     <= '0;
      step_latch <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          // step only counts when run is low; it is not queued otherwise.
          if (!run && step) step_latch <= 1'b1;
        end
        S_FETCH: begin
          ir <= rom_data;
        end
        S_EXEC: begin
          if (!keeps_status(opcode)) status <= flags_in;
          step_latch <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
